press_event_controller: RTL and testbench

- Sequences the push-button front end after the two-flop synchronizer.
- Qualifies the synchronized press level with a debounce counter and emits a single-cycle press pulse, the same contract as the single pulser.
- Adds auto-repeat pulses while the button is held and a release pulse on debounced release.
- Sits between the synchronizer output and downstream counters/FSMs that consume one-cycle button events.

---
 rtl/press_event_controller.sv | 134 +++++++++++++
 tb/tb_press_event_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/press_event_controller.sv
// Debounced push-button event sequencer: turns a synchronized press level into
// one-cycle press, auto-repeat and release pulses plus a debounced level.
module press_event_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic syncpress_i,
  input  logic en_i,
  output logic SP_o,
  output logic RP_o,
  output logic REL_o,
  output logic pressed_o
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_REL
  } state_t;

  // Each terminal count is "parameter minus one" because the edge that reaches
  // it is itself the N-th qualifying edge.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               DEB_ONE   = (DEBOUNCE_CYCLES == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sp, rp, rel, pressed;

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sp      <= 1'b0;
      rp      <= 1'b0;
      rel     <= 1'b0;
      pressed <= 1'b0;
    end else begin
      // NOTE: pulses default low every edge so each one lasts exactly one cycle.
      sp  <= 1'b0;
      rp  <= 1'b0;
      rel <= 1'b0;
      if (!en_i) begin
        state   <= IDLE;
        cnt     <= '0;
        pressed <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (syncpress_i) begin
              if (DEB_ONE) begin
                state   <= HELD;
                cnt     <= '0;
                sp      <= 1'b1;
                pressed <= 1'b1;
              end else begin
                state <= DEB_PRESS;
                cnt   <= CNT_ONE;
              end
            end
          end
          DEB_PRESS: begin
            if (!syncpress_i) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state   <= HELD;
              cnt     <= '0;
              sp      <= 1'b1;
              pressed <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HELD, REPEAT: begin
            if (!syncpress_i) begin
              if (DEB_ONE) begin
                state   <= IDLE;
                cnt     <= '0;
                rel     <= 1'b1;
                pressed <= 1'b0;
              end else begin
                state <= DEB_REL;
                cnt   <= CNT_ONE;
              end
            end else if (cnt == ((state == HELD) ? HOLD_LAST : REP_LAST)) begin
              // Staying in REPEAT also restarts the interval.
              state <= REPEAT;
              cnt   <= '0;
              rp    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DEB_REL: begin
            if (syncpress_i) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state   <= IDLE;
              cnt     <= '0;
              rel     <= 1'b1;
              pressed <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SP_o      = sp;
  assign RP_o      = rp;
  assign REL_o     = rel;
  assign pressed_o = pressed;

endmodule

// File: tb/tb_press_event_controller.sv
// Scoreboard bench for press_event_controller: expected pulses are queued with
// the clock edge they must appear on; a monitor pops them as the DUT pulses.
module tb_press_event_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic syncpress_i = 1'b0;
  logic en_i = 1'b1;
  logic SP_o, RP_o, REL_o, pressed_o;

  press_event_controller #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(16),
    .REPEAT_CYCLES(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .syncpress_i(syncpress_i),
    .en_i(en_i),
    .SP_o(SP_o),
    .RP_o(RP_o),
    .REL_o(REL_o),
    .pressed_o(pressed_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; edge k of a test lands on cycle base + k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] K_SP  = 3'b100;
  localparam logic [2:0] K_RP  = 3'b010;
  localparam logic [2:0] K_REL = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  int  base = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input int edge_no);
    exp_q.push_back('{kind: kind, at: base + edge_no});
  endtask

  task automatic run(input logic press, input logic en, input int n);
    repeat (n) begin
      @(negedge clk);
      syncpress_i = press;
      en_i        = en;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: any pulse must match the head of the queue in kind and cycle.
  always @(negedge clk) begin
    ev_t ev;
    if (rst && (SP_o || RP_o || REL_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got %b want none (cycle %0d)",
                 {SP_o, RP_o, REL_o}, cyc);
      end else begin
        ev = exp_q.pop_front();
        check("pulse_kind", int'({SP_o, RP_o, REL_o}), int'(ev.kind));
        check("pulse_cycle", cyc, ev.at);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("reset_outputs", int'({SP_o, RP_o, REL_o, pressed_o}), 0);
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 1'b1, 2);

    // Clean press for 10 edges then clean release
    base = cyc;
    expect_pulse(K_SP, 4);
    expect_pulse(K_REL, 14);
    run(1'b1, 1'b1, 3);
    check("clean_pressed_e3", int'(pressed_o), 0);
    run(1'b1, 1'b1, 1);
    check("clean_pressed_e4", int'(pressed_o), 1);
    run(1'b1, 1'b1, 6);
    run(1'b0, 1'b1, 3);
    check("clean_pressed_rel3", int'(pressed_o), 1);
    run(1'b0, 1'b1, 1);
    check("clean_pressed_rel4", int'(pressed_o), 0);
    run(1'b0, 1'b1, 2);

    // Press bounce: high 3 / low 1 / high 3 / low
    base = cyc;
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 1);
    run(1'b1, 1'b1, 3);
    check("bounce_pressed_mid", int'(pressed_o), 0);
    run(1'b0, 1'b1, 3);
    check("bounce_pressed_end", int'(pressed_o), 0);

    // Long hold for 40 edges: repeats at 20, 28, 36
    base = cyc;
    expect_pulse(K_SP, 4);
    expect_pulse(K_RP, 20);
    expect_pulse(K_RP, 28);
    expect_pulse(K_RP, 36);
    expect_pulse(K_REL, 44);
    run(1'b1, 1'b1, 40);
    check("hold_pressed", int'(pressed_o), 1);
    run(1'b0, 1'b1, 4);
    check("hold_released", int'(pressed_o), 0);
    run(1'b0, 1'b1, 2);

    // Release bounce from HELD: low 2 / high 1 / low 4
    base = cyc;
    expect_pulse(K_SP, 4);
    expect_pulse(K_REL, 13);
    run(1'b1, 1'b1, 6);
    run(1'b0, 1'b1, 2);
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 3);
    check("relb_pressed_e12", int'(pressed_o), 1);
    run(1'b0, 1'b1, 1);
    check("relb_pressed_e13", int'(pressed_o), 0);
    run(1'b0, 1'b1, 2);

    // Enable drop in REPEAT, then re-enable with button still held
    base = cyc;
    expect_pulse(K_SP, 4);
    expect_pulse(K_RP, 20);
    run(1'b1, 1'b1, 22);
    run(1'b1, 1'b0, 1);
    check("en_drop_pressed", int'(pressed_o), 0);
    run(1'b1, 1'b0, 2);
    base = cyc;
    expect_pulse(K_SP, 4);
    expect_pulse(K_REL, 10);
    run(1'b1, 1'b1, 3);
    check("reen_pressed_e3", int'(pressed_o), 0);
    run(1'b1, 1'b1, 1);
    check("reen_pressed_e4", int'(pressed_o), 1);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 4);
    run(1'b0, 1'b1, 2);

    // Async reset mid-cycle while the repeat pulse is high
    base = cyc;
    expect_pulse(K_SP, 4);
    run(1'b1, 1'b1, 20);
    check("pre_reset_rp", int'(RP_o), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", int'({SP_o, RP_o, REL_o, pressed_o}), 0);
    run(1'b1, 1'b1, 2);
    check("held_reset_outputs", int'({SP_o, RP_o, REL_o, pressed_o}), 0);
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 1'b1, 2);
    base = cyc;
    expect_pulse(K_SP, 4);
    expect_pulse(K_REL, 9);
    run(1'b1, 1'b1, 3);
    check("post_reset_pressed_e3", int'(pressed_o), 0);
    run(1'b1, 1'b1, 1);
    check("post_reset_pressed_e4", int'(pressed_o), 1);
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 4);
    run(1'b0, 1'b1, 3);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
